// File: rtl/pc_sequencer.sv
// Program counter and fetch-address sequencer: resolves PCsrc redirects against the
// sequential stream and issues addresses to instruction memory over valid/ready.
module pc_sequencer #(
    parameter int unsigned              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]        RESET_ADDR = '0,
    parameter int unsigned              STEP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [1:0]        PCsrc,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [ADDR_W-1:0] immediate,
    input  logic [ADDR_W-1:0] result,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] currentAddress,
    output logic [ADDR_W-1:0] currentAddress_2,
    output logic [ADDR_W-1:0] currentAddress_immediate,
    output logic              flush,
    output logic              misaligned,
    output logic              illegal_src
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        PEND  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pend_q;
    logic              fetch_valid_q;
    logic              flush_q;
    logic              misaligned_q;
    logic              illegal_q;

    logic [ADDR_W-1:0] raw_target_d;
    logic [ADDR_W-1:0] target_d;
    logic [ADDR_W-1:0] seq_addr_d;
    logic              redir_d;
    logic              illegal_d;
    logic              xfer_d;

    always_comb begin
        raw_target_d = '0;
        unique case (PCsrc)
            2'd0:    raw_target_d = base_address + STEP_V;
            2'd1:    raw_target_d = base_address + immediate;
            2'd2:    raw_target_d = result;
            default: raw_target_d = '0;
        endcase
    end

    assign target_d   = {raw_target_d[ADDR_W-1:1], 1'b0};
    assign seq_addr_d = addr_q + STEP_V;
    assign redir_d    = redirect_valid && (PCsrc != 2'd3);
    assign illegal_d  = redirect_valid && (PCsrc == 2'd3);
    assign xfer_d     = fetch_valid_q && fetch_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            addr_q        <= RESET_ADDR;
            pend_q        <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            misaligned_q  <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            flush_q      <= 1'b0;
            misaligned_q <= redir_d && raw_target_d[0];
            illegal_q    <= illegal_d;

            unique case (state_q)
                BOOT: begin
                    if (redir_d) begin
                        addr_q  <= target_d;
                        flush_q <= 1'b1;
                    end
                    state_q       <= stall ? HOLD : FETCH;
                    fetch_valid_q <= !stall;
                end
                FETCH: begin
                    if (xfer_d) begin
                        // A redirect in the accepting cycle replaces the increment.
                        if (redir_d) begin
                            addr_q  <= target_d;
                            flush_q <= 1'b1;
                        end else begin
                            addr_q <= seq_addr_d;
                        end
                        state_q       <= stall ? HOLD : FETCH;
                        fetch_valid_q <= !stall;
                    end else if (redir_d) begin
                        pend_q  <= target_d;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (xfer_d) begin
                        addr_q        <= redir_d ? target_d : pend_q;
                        flush_q       <= 1'b1;
                        pend_q        <= '0;
                        state_q       <= stall ? HOLD : FETCH;
                        fetch_valid_q <= !stall;
                    end else if (redir_d) begin
                        pend_q <= target_d;
                    end
                end
                HOLD: begin
                    if (redir_d) begin
                        addr_q  <= target_d;
                        flush_q <= 1'b1;
                    end
                    if (!stall) begin
                        state_q       <= FETCH;
                        fetch_valid_q <= 1'b1;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign fetch_valid              = fetch_valid_q;
    assign currentAddress           = addr_q;
    assign currentAddress_2         = addr_q + STEP_V;
    assign currentAddress_immediate = addr_q + immediate;
    assign flush                    = flush_q;
    assign misaligned               = misaligned_q;
    assign illegal_src              = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed cycle-by-cycle vectors for pc_sequencer plus an asynchronous-reset sequence.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [1:0]  PCsrc;
    logic [15:0] base_address;
    logic [15:0] immediate;
    logic [15:0] result;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [15:0] currentAddress;
    logic [15:0] currentAddress_2;
    logic [15:0] currentAddress_immediate;
    logic        flush;
    logic        misaligned;
    logic        illegal_src;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W     (16),
        .RESET_ADDR (16'h0000),
        .STEP       (2)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .redirect_valid           (redirect_valid),
        .PCsrc                    (PCsrc),
        .base_address             (base_address),
        .immediate                (immediate),
        .result                   (result),
        .stall                    (stall),
        .fetch_ready              (fetch_ready),
        .fetch_valid              (fetch_valid),
        .currentAddress           (currentAddress),
        .currentAddress_2         (currentAddress_2),
        .currentAddress_immediate (currentAddress_immediate),
        .flush                    (flush),
        .misaligned               (misaligned),
        .illegal_src              (illegal_src)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [1:0]  ps;
        logic [15:0] base;
        logic [15:0] imm;
        logic [15:0] res;
        logic        stall;
        logic        rdy;
        logic        fv;
        logic [15:0] a;
        logic        fl;
        logic        mi;
        logic        il;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic void v(input logic r, input logic rv, input logic [1:0] ps,
                              input logic [15:0] base, input logic [15:0] imm,
                              input logic [15:0] res, input logic st, input logic rdy,
                              input logic fv, input logic [15:0] a,
                              input logic fl, input logic mi, input logic il);
        vec_t t;
        t.rst = r;  t.rv = rv;  t.ps = ps;  t.base = base; t.imm = imm; t.res = res;
        t.stall = st; t.rdy = rdy; t.fv = fv; t.a = a; t.fl = fl; t.mi = mi; t.il = il;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic fv, input logic [15:0] a,
                             input logic fl, input logic mi, input logic il,
                             input logic [15:0] imm);
        n_vec++;
        chk("fetch_valid", idx, {15'b0, fetch_valid}, {15'b0, fv});
        chk("currentAddress", idx, currentAddress, a);
        chk("currentAddress_2", idx, currentAddress_2, a + 16'd2);
        chk("currentAddress_immediate", idx, currentAddress_immediate, a + imm);
        chk("flush", idx, {15'b0, flush}, {15'b0, fl});
        chk("misaligned", idx, {15'b0, misaligned}, {15'b0, mi});
        chk("illegal_src", idx, {15'b0, illegal_src}, {15'b0, il});
    endtask

    initial begin
        //  rst rv ps  base      imm       res      st rdy | fv addr     fl mi il
        v(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 0); // 0 reset
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 0); // 1 BOOT->FETCH
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0002, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0004, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0006, 0, 0, 0);
        v(0, 1, 2, 16'h0000, 16'h0000, 16'hFFFC, 0, 1,   1, 16'hFFFC, 1, 0, 0); // 5 redirect+xfer
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'hFFFE, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 0); // 7 wrap
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0002, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0004, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0006, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0008, 0, 0, 0);
        v(0, 1, 1, 16'h0004, 16'h0020, 16'h0000, 0, 0,   1, 16'h0008, 0, 0, 0); // 12 -> PEND
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0008, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0024, 1, 0, 0); // 14 pend applied
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0026, 0, 0, 0);
        v(0, 1, 2, 16'h0000, 16'h0000, 16'h0100, 0, 0,   1, 16'h0026, 0, 0, 0); // 16
        v(0, 1, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0,   1, 16'h0026, 0, 0, 0); // 17 newest wins
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0042, 1, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0,   1, 16'h0042, 0, 0, 0); // 19 request held
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1,   0, 16'h0044, 0, 0, 0); // 20 -> HOLD
        v(0, 1, 2, 16'h0000, 16'h0000, 16'h0031, 1, 1,   0, 16'h0030, 1, 1, 0); // 21 HOLD redirect
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1,   0, 16'h0030, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0030, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0032, 0, 0, 0);
        v(0, 1, 3, 16'h0000, 16'h0000, 16'h0200, 0, 1,   1, 16'h0034, 0, 0, 1); // 25 illegal
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0036, 0, 0, 0);
        v(0, 1, 1, 16'h0101, 16'h0004, 16'h0000, 0, 0,   1, 16'h0036, 0, 1, 0); // 27 odd into PEND
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0104, 1, 0, 0);
        v(0, 1, 0, 16'h0200, 16'h0000, 16'h0000, 1, 1,   0, 16'h0202, 1, 0, 0); // 29 redirect+stall
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0202, 0, 0, 0);
        v(0, 1, 1, 16'h0010, 16'hFFF0, 16'h0000, 0, 1,   1, 16'h0000, 1, 0, 0); // 31 negative imm
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0002, 0, 0, 0);
        v(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 0); // 33 reset again
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1,   0, 16'h0000, 0, 0, 0); // 34 BOOT->HOLD
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1,   1, 16'h0002, 0, 0, 0);
        v(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0,   1, 16'h0002, 0, 0, 0); // 37 mid-handshake

        rst = 1'b1; redirect_valid = 1'b0; PCsrc = 2'd0; base_address = '0;
        immediate = '0; result = '0; stall = 1'b0; fetch_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            redirect_valid = tbl[i].rv;
            PCsrc          = tbl[i].ps;
            base_address   = tbl[i].base;
            immediate      = tbl[i].imm;
            result         = tbl[i].res;
            stall          = tbl[i].stall;
            fetch_ready    = tbl[i].rdy;
            @(posedge clk);
            #1;
            check_all(i, tbl[i].fv, tbl[i].a, tbl[i].fl, tbl[i].mi, tbl[i].il, tbl[i].imm);
        end

        // Asynchronous reset in the middle of an unaccepted fetch of 0002.
        @(negedge clk);
        redirect_valid = 1'b0; immediate = 16'h0000; fetch_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_all(100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1 check_all(101, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b0; fetch_ready = 1'b1;
        @(posedge clk);
        #1 check_all(102, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1 check_all(103, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
